controle_multiciclo: RTL and testbench
======================================

# controle_multiciclo

Parametrised multicycle control unit for the RISC-V datapath, replacing the hard-coded IF/ID/FIM loop at the top level. Walks each instruction through IF→ID→EX→MEM→WB with per-class paths for lw, sw, R-type (sub/xor/srl), addi and beq. Adds a memory ready handshake with timeout, an illegal-opcode trap and a parametrised retire count for end of program. It sits beside the register bank, ALU and memories and drives their enables.

## Interface
- PROG_LEN, 7: instructions retired before entering FIM; must be ≥1.
- CNT_W, 16: width of the retire counter; PROG_LEN < 2^CNT_W.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles on mem_ready before trapping; must be ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE.
- opcode  in  7  instruction opcode from the decoder; valid in ID.
- zero  in  1  ALU zero flag; valid in EX.
- mem_ready  in  1  memory access completes in this cycle.
- estado  out  3  current state code.
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
- alu_src, mem_to_reg, pc_src, branch  out  1 each  mux selects and branch flag.
- instr_count  out  CNT_W  retired instructions.
- halted  out  1  in FIM or ERR.
- error  out  1  in ERR.

## Operation
- State codes: IF=000, ID=001, EX=010, MEM=011, WB=100, IDLE=101, FIM=110, ERR=111.
- Opcodes: lw=0000011, sw=0100011, R=0110011, addi=0010011, beq=1100011. Any other opcode is illegal.
- opcode is latched into an internal register in ID. Outputs are a Moore decode of the state, the latched opcode, zero and mem_ready.
- IDLE: all enables are 0. start=1 moves to IF.
- IF: mem_read=1. If mem_ready=1, assert ir_write=1 and pc_write=1 (pc_src=0, PC+4) and go to ID. Otherwise stay in IF.
- ID: legal opcode goes to EX; illegal opcode goes to ERR.
- EX by class:
  - R: alu_src=0, go to WB.
  - addi: alu_src=1, go to WB.
  - lw/sw: alu_src=1, go to MEM.
  - beq: alu_src=0, branch=1, pc_src=1, pc_write=zero; the instruction retires.
- MEM:
  - lw: mem_read=1; go to WB on mem_ready.
  - sw: mem_write=1; retire on mem_ready.
  - Stay in MEM while mem_ready=0.
- WB: reg_write=1; mem_to_reg=1 only for lw. The instruction retires.
- Retire: instr_count increments by 1. If the new value equals PROG_LEN, go to FIM; otherwise go to IF.
- Wait counter: counts consecutive cycles in IF or MEM with mem_ready=0. It clears on state change. When it reaches MEM_TIMEOUT, go to ERR on that edge.
- FIM and ERR: halted=1, all enables 0, the state holds until rst. ERR also sets error=1.
- Reset values: estado=IDLE, instr_count=0, wait counter=0, latched opcode=0, all 1-bit outputs 0.

## Timing
- Latency with mem_ready tied high:
  - beq: 3 cycles.
  - R, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each low mem_ready cycle in IF or MEM adds 1 cycle.
- Retire and the FIM transition happen on the same edge. halted=1 in the cycle after the last instruction's final state.
- rst wins over every other input on the same edge, including mid-MEM and mid-wait. The following cycle is IDLE with zeroed outputs.
- start held high while not in IDLE has no effect. start held high in IDLE starts one run only; after FIM, a new run needs rst.
- If mem_ready rises on the same edge the counter would reach MEM_TIMEOUT, mem_ready wins: the access completes and no trap occurs.
- Illegal opcode: exactly one cycle in ID, then ERR. pc_write has already fired in IF.

## Test plan
- Reset, start, then opcodes sub, xor, addi, srl, lw, sw, beq (zero=1) with mem_ready=1 and PROG_LEN=7 → instr_count=7, halted=1 at cycle 28 after start, and exactly one beq-cycle pulse of pc_write with pc_src=1.
- lw with mem_ready low for 3 cycles in MEM → mem_read held 4 cycles, reg_write and mem_to_reg pulse once, total latency 8 cycles.
- beq with zero=0 → branch=1 in EX, pc_write=0 in EX, return to IF after 3 cycles.
- Opcode 1111111 → ERR after ID, with error=1 and halted=1 held for ≥10 cycles; instr_count is unchanged.
- mem_ready=0 held in IF with MEM_TIMEOUT=15 → ERR entered on the 15th wait edge; mem_ready rising exactly at that edge → ID instead.
- rst asserted mid-MEM of an sw → next cycle estado=101, mem_write=0, instr_count=0; a new start runs normally.

Source files
------------

// File: rtl/controle_multiciclo_if.sv
// controle_multiciclo_if: datapath-side handshake and enable bundle of the multicycle control unit
interface controle_multiciclo_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [6:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic [2:0]       estado;
   logic             pc_write;
   logic             ir_write;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             alu_src;
   logic             mem_to_reg;
   logic             pc_src;
   logic             branch;
   logic [CNT_W-1:0] instr_count;
   logic             halted;
   logic             error;
   modport master (
      input  start, opcode, zero, mem_ready,
      output estado, pc_write, ir_write, reg_write, mem_read, mem_write,
             alu_src, mem_to_reg, pc_src, branch, instr_count, halted, error
   );
   modport slave (
      output start, opcode, zero, mem_ready,
      input  estado, pc_write, ir_write, reg_write, mem_read, mem_write,
             alu_src, mem_to_reg, pc_src, branch, instr_count, halted, error
   );
endinterface

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle IF/ID/EX/MEM/WB control FSM with memory timeout, illegal-opcode trap and retire count
module controle_multiciclo #(
   parameter int PROG_LEN    = 7,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input logic                   clk,
   input logic                   rst,
   controle_multiciclo_if.master bus
);
   localparam int            WW     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] W_LAST = WW'(MEM_TIMEOUT - 1);
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EX   = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_IDLE = 3'b101,
      S_FIM  = 3'b110,
      S_ERR  = 3'b111
   } state_t;
   state_t           r_state;
   logic [6:0]       r_opcode;
   logic [CNT_W-1:0] r_cnt;
   logic [WW-1:0]    r_wait;
   logic             w_lw, w_sw, w_addi, w_beq, w_legal, w_retire, w_timeout;
   logic             w_if, w_ex, w_mem, w_wb;
   logic [CNT_W-1:0] w_cnt_inc;
   assign w_lw      = r_opcode == OP_LW;
   assign w_sw      = r_opcode == OP_SW;
   assign w_addi    = r_opcode == OP_ADDI;
   assign w_beq     = r_opcode == OP_BEQ;
   assign w_legal   = bus.opcode inside {OP_LW, OP_SW, OP_R, OP_ADDI, OP_BEQ};
   assign w_if      = r_state == S_IF;
   assign w_ex      = r_state == S_EX;
   assign w_mem     = r_state == S_MEM;
   assign w_wb      = r_state == S_WB;
   assign w_retire  = (w_ex & w_beq) | (w_mem & w_sw & bus.mem_ready) | w_wb;
   assign w_timeout = r_wait == W_LAST;
   assign w_cnt_inc = r_cnt + 1'b1;
   // Moore decode of state and latched opcode, qualified by zero/mem_ready where the access or branch completes
   assign bus.estado      = r_state;
   assign bus.mem_read    = w_if | (w_mem & w_lw);
   assign bus.ir_write    = w_if & bus.mem_ready;
   assign bus.pc_write    = (w_if & bus.mem_ready) | (w_ex & w_beq & bus.zero);
   assign bus.reg_write   = w_wb;
   assign bus.mem_write   = w_mem & w_sw;
   assign bus.alu_src     = w_ex & (w_addi | w_lw | w_sw);
   assign bus.mem_to_reg  = w_wb & w_lw;
   assign bus.pc_src      = w_ex & w_beq;
   assign bus.branch      = w_ex & w_beq;
   assign bus.instr_count = r_cnt;
   assign bus.halted      = r_state == S_FIM || r_state == S_ERR;
   assign bus.error       = r_state == S_ERR;
   // state walk, retire counting and wait-cycle watchdog; mem_ready beats the timeout on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_cnt    <= '0;
         r_wait   <= '0;
      end else begin
         r_wait <= '0;
         if (w_retire) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == CNT_W'(PROG_LEN)) ? S_FIM : S_IF;
         end else begin
            case (r_state)
               S_IDLE: if (bus.start) r_state <= S_IF;
               S_IF, S_MEM:
                  if (bus.mem_ready) r_state <= w_if ? S_ID : S_WB;
                  else if (w_timeout) r_state <= S_ERR;
                  else r_wait <= r_wait + 1'b1;
               S_ID: begin
                  r_opcode <= bus.opcode;
                  r_state  <= w_legal ? S_EX : S_ERR;
               end
               S_EX: r_state <= (w_lw | w_sw) ? S_MEM : S_WB;
               default: r_state <= r_state;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: cycle-by-cycle vector bench for the multicycle control unit
module tb_controle_multiciclo;
   localparam int CNT_W = 16;
   localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011;
   localparam logic [2:0] S_WB = 3'b100, S_IDLE = 3'b101, S_FIM = 3'b110, S_ERR = 3'b111;
   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] AD = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111, XX = 7'b0000000;
   // enable order: pc_write ir_write reg_write mem_read mem_write alu_src mem_to_reg pc_src branch
   localparam logic [8:0] E0   = 9'b000000000;
   localparam logic [8:0] EIF  = 9'b110100000;
   localparam logic [8:0] EIFW = 9'b000100000;
   localparam logic [8:0] EALU = 9'b000001000;
   localparam logic [8:0] EBT  = 9'b100000011;
   localparam logic [8:0] EBN  = 9'b000000011;
   localparam logic [8:0] ELW  = 9'b000100000;
   localparam logic [8:0] ESW  = 9'b000010000;
   localparam logic [8:0] EWB  = 9'b001000000;
   localparam logic [8:0] EWBL = 9'b001000100;
   typedef struct {
      logic        r;
      logic        s;
      logic [6:0]  op;
      logic        z;
      logic        m;
      logic [2:0]  st;
      logic [8:0]  en;
      logic [15:0] cnt;
      logic        h;
      logic        e;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [8:0] en;
   vec_t exp_q[$];
   vec_t prog[$];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   controle_multiciclo_if #(.CNT_W(CNT_W)) bus ();
   controle_multiciclo #(.PROG_LEN(7), .CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   assign en = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.alu_src, bus.mem_to_reg, bus.pc_src, bus.branch};
   function automatic vec_t mk(int r, int s, logic [6:0] op, int z, int m,
                               logic [2:0] st, logic [8:0] en_x, int cnt, int h, int e);
      vec_t t;
      t.r   = r[0];
      t.s   = s[0];
      t.op  = op;
      t.z   = z[0];
      t.m   = m[0];
      t.st  = st;
      t.en  = en_x;
      t.cnt = cnt[15:0];
      t.h   = h[0];
      t.e   = e[0];
      return t;
   endfunction
   // drive one cycle of inputs at negedge, queue its expectation, compare before the next posedge
   task automatic step(input string nm, input vec_t t);
      vec_t x;
      @(negedge clk);
      rst           = t.r;
      bus.start     = t.s;
      bus.opcode    = t.op;
      bus.zero      = t.z;
      bus.mem_ready = t.m;
      exp_q.push_back(t);
      #1;
      x = exp_q.pop_front();
      checks++;
      if ({bus.estado, en, bus.instr_count, bus.halted, bus.error} !== {x.st, x.en, x.cnt, x.h, x.e}) begin
         errors++;
         $display("FAIL %s: got st=%b en=%b cnt=%0d h=%b e=%b, want st=%b en=%b cnt=%0d h=%b e=%b",
                  nm, bus.estado, en, bus.instr_count, bus.halted, bus.error, x.st, x.en, x.cnt, x.h, x.e);
      end
   endtask
   task automatic c(input string nm, input int r, input int s, input logic [6:0] op, input int z,
                    input int m, input logic [2:0] st, input logic [8:0] en_x, input int cnt,
                    input int h, input int e);
      step(nm, mk(r, s, op, z, m, st, en_x, cnt, h, e));
   endtask
   task automatic p(input logic [2:0] st, input logic [6:0] op, input logic [8:0] en_x, input int cnt, input int h);
      prog.push_back(mk(0, 1, op, 1, 1, st, en_x, cnt, h, 0));
   endtask
   task automatic rst_pulse();
      @(negedge clk);
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.opcode    = XX;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
   endtask
   initial begin
      bus.start     = 1'b0;
      bus.opcode    = XX;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      // full program sub, xor, addi, srl, lw, sw, beq(taken) with start held high throughout
      p(S_IDLE, XX, E0, 0, 0);
      p(S_IF, XX, EIF, 0, 0); p(S_ID, RT, E0, 0, 0); p(S_EX, XX, E0, 0, 0);   p(S_WB, XX, EWB, 0, 0);
      p(S_IF, XX, EIF, 1, 0); p(S_ID, RT, E0, 1, 0); p(S_EX, XX, E0, 1, 0);   p(S_WB, XX, EWB, 1, 0);
      p(S_IF, XX, EIF, 2, 0); p(S_ID, AD, E0, 2, 0); p(S_EX, XX, EALU, 2, 0); p(S_WB, XX, EWB, 2, 0);
      p(S_IF, XX, EIF, 3, 0); p(S_ID, RT, E0, 3, 0); p(S_EX, XX, E0, 3, 0);   p(S_WB, XX, EWB, 3, 0);
      p(S_IF, XX, EIF, 4, 0); p(S_ID, LW, E0, 4, 0); p(S_EX, XX, EALU, 4, 0); p(S_MEM, XX, ELW, 4, 0);
      p(S_WB, XX, EWBL, 4, 0);
      p(S_IF, XX, EIF, 5, 0); p(S_ID, SW, E0, 5, 0); p(S_EX, XX, EALU, 5, 0); p(S_MEM, XX, ESW, 5, 0);
      p(S_IF, XX, EIF, 6, 0); p(S_ID, BQ, E0, 6, 0); p(S_EX, XX, EBT, 6, 0);
      for (int i = 0; i < 4; i++) p(S_FIM, XX, E0, 7, 1);
      rst_pulse();
      c("reset idle", 0, 0, XX, 0, 1, S_IDLE, E0, 0, 0, 0);
      c("idle no start", 0, 0, XX, 0, 1, S_IDLE, E0, 0, 0, 0);
      for (int i = 0; i < prog.size(); i++) step($sformatf("prog[%0d]", i), prog[i]);
      // lw with three stalled memory cycles, then an untaken beq
      rst_pulse();
      c("lw idle", 0, 1, XX, 0, 1, S_IDLE, E0, 0, 0, 0);
      c("lw if", 0, 0, XX, 0, 1, S_IF, EIF, 0, 0, 0);
      c("lw id", 0, 0, LW, 0, 1, S_ID, E0, 0, 0, 0);
      c("lw ex", 0, 0, XX, 0, 1, S_EX, EALU, 0, 0, 0);
      for (int i = 0; i < 3; i++) c($sformatf("lw stall%0d", i), 0, 0, XX, 0, 0, S_MEM, ELW, 0, 0, 0);
      c("lw mem", 0, 0, XX, 0, 1, S_MEM, ELW, 0, 0, 0);
      c("lw wb", 0, 0, XX, 0, 1, S_WB, EWBL, 0, 0, 0);
      c("beqn if", 0, 0, XX, 0, 1, S_IF, EIF, 1, 0, 0);
      c("beqn id", 0, 0, BQ, 0, 1, S_ID, E0, 1, 0, 0);
      c("beqn ex", 0, 0, XX, 0, 1, S_EX, EBN, 1, 0, 0);
      // sw interrupted by reset mid-MEM, restart, then an illegal opcode traps
      c("sw if", 0, 0, XX, 0, 1, S_IF, EIF, 2, 0, 0);
      c("sw id", 0, 0, SW, 0, 1, S_ID, E0, 2, 0, 0);
      c("sw ex", 0, 0, XX, 0, 1, S_EX, EALU, 2, 0, 0);
      c("sw mem", 0, 0, XX, 0, 0, S_MEM, ESW, 2, 0, 0);
      c("sw mem rst", 1, 0, XX, 0, 0, S_MEM, ESW, 2, 0, 0);
      c("post rst", 0, 0, XX, 0, 0, S_IDLE, E0, 0, 0, 0);
      c("re idle", 0, 1, XX, 0, 1, S_IDLE, E0, 0, 0, 0);
      c("re if", 0, 0, XX, 0, 1, S_IF, EIF, 0, 0, 0);
      c("re id", 0, 0, AD, 0, 1, S_ID, E0, 0, 0, 0);
      c("re ex", 0, 0, XX, 0, 1, S_EX, EALU, 0, 0, 0);
      c("re wb", 0, 0, XX, 0, 1, S_WB, EWB, 0, 0, 0);
      c("ill if", 0, 0, XX, 0, 1, S_IF, EIF, 1, 0, 0);
      c("ill id", 0, 0, BAD, 0, 1, S_ID, E0, 1, 0, 0);
      for (int i = 0; i < 10; i++) c($sformatf("ill err%0d", i), 0, 1, XX, 1, 1, S_ERR, E0, 1, 1, 1);
      // fetch stalled until the watchdog fires on the 15th wait edge
      rst_pulse();
      c("to idle", 0, 1, XX, 0, 0, S_IDLE, E0, 0, 0, 0);
      for (int i = 0; i < 15; i++) c($sformatf("to wait%0d", i), 0, 0, XX, 0, 0, S_IF, EIFW, 0, 0, 0);
      c("to err0", 0, 0, XX, 0, 1, S_ERR, E0, 0, 1, 1);
      c("to err1", 0, 1, XX, 0, 1, S_ERR, E0, 0, 1, 1);
      // mem_ready arriving on the would-be timeout edge wins; then a lw times out in MEM
      rst_pulse();
      c("race idle", 0, 1, XX, 0, 0, S_IDLE, E0, 0, 0, 0);
      for (int i = 0; i < 14; i++) c($sformatf("race wait%0d", i), 0, 0, XX, 0, 0, S_IF, EIFW, 0, 0, 0);
      c("race if", 0, 0, XX, 0, 1, S_IF, EIF, 0, 0, 0);
      c("race id", 0, 0, RT, 0, 1, S_ID, E0, 0, 0, 0);
      c("race ex", 0, 0, XX, 0, 1, S_EX, E0, 0, 0, 0);
      c("race wb", 0, 0, XX, 0, 1, S_WB, EWB, 0, 0, 0);
      c("mto if", 0, 0, XX, 0, 1, S_IF, EIF, 1, 0, 0);
      c("mto id", 0, 0, LW, 0, 1, S_ID, E0, 1, 0, 0);
      c("mto ex", 0, 0, XX, 0, 1, S_EX, EALU, 1, 0, 0);
      for (int i = 0; i < 15; i++) c($sformatf("mto wait%0d", i), 0, 0, XX, 0, 0, S_MEM, ELW, 1, 0, 0);
      c("mto err", 0, 0, XX, 0, 1, S_ERR, E0, 1, 1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
